four_to_two_encoder: RTL and testbench



---
 rtl/four_to_two_encoder_pkg.sv | 32 +++
 rtl/four_to_two_encoder_if.sv | 33 +++
 rtl/four_to_two_encoder_prio_pick4.sv | 47 ++++
 rtl/four_to_two_encoder.sv | 133 +++++++++++++
 tb/tb_four_to_two_encoder.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/four_to_two_encoder_pkg.sv
// Shared types and constants for the sequential 4-to-2 encoder.
// Holds the line/code widths, the FSM state encoding and small vector helpers.
package encoder_pkg;

    localparam int unsigned N_LINES = 4;
    localparam int unsigned CODE_W  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // One-hot expansion of a 2-bit code; the inverse of the encoding itself.
    function automatic logic [N_LINES-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
        logic [N_LINES-1:0] vec;
        case (code)
            2'd0:    vec = 4'b0001;
            2'd1:    vec = 4'b0010;
            2'd2:    vec = 4'b0100;
            2'd3:    vec = 4'b1000;
            default: vec = 4'b0000;
        endcase
        return vec;
    endfunction

    // Rising-edge detector over the request lines.
    function automatic logic [N_LINES-1:0] rise_of(input logic [N_LINES-1:0] cur,
                                                   input logic [N_LINES-1:0] prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/four_to_two_encoder_if.sv
// Request/report bundle of the 4-to-2 encoder.
// master = event source + consumer side, slave = the encoder.
interface four_to_two_encoder_if;

    logic [encoder_pkg::N_LINES-1:0] i;
    logic                            ready;
    logic                            A;
    logic                            B;
    logic                            valid;
    logic [encoder_pkg::N_LINES-1:0] pending;
    logic                            overflow;

    modport master (
        output i,
        output ready,
        input  A,
        input  B,
        input  valid,
        input  pending,
        input  overflow
    );

    modport slave (
        input  i,
        input  ready,
        output A,
        output B,
        output valid,
        output pending,
        output overflow
    );

endinterface

// File: rtl/four_to_two_encoder_prio_pick4.sv
// Combinational picker over a 4-bit pending vector.
// ROUND_ROBIN_EN: ascending search from start with wrap; otherwise fixed 3>2>1>0.
module prio_pick4
    import encoder_pkg::*;
(
    input  logic [N_LINES-1:0] vec,
    input  logic [CODE_W-1:0]  start,
    output logic [CODE_W-1:0]  code,
    output logic               any
);

`ifdef ROUND_ROBIN_EN
    logic [2*N_LINES-1:0] dbl_s;
    logic [N_LINES-1:0]   rot_s;
    logic [CODE_W-1:0]    off_s;

    // Rotate so that bit 0 is the start line, then take the lowest set bit.
    always_comb begin
        dbl_s = {vec, vec};
        rot_s = dbl_s[start +: N_LINES];
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        code = start + off_s;
        any  = |vec;
    end
`else
    logic unused_start_s;

    // Fixed priority: highest index wins.
    always_comb begin
        unused_start_s = ^start;
        casez (vec)
            4'b1???: code = 2'd3;
            4'b01??: code = 2'd2;
            4'b001?: code = 2'd1;
            default: code = 2'd0;
        endcase
        any = |vec;
    end
`endif

endmodule

// File: rtl/four_to_two_encoder.sv
// Sequential 4-to-2 encoder: captures request events into a pending vector and
// reports each as {A,B} over valid/ready. Optional macro: ROUND_ROBIN_EN.
module four_to_two_encoder
    import encoder_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    four_to_two_encoder_if.slave bus
);

    logic [N_LINES-1:0] prev_i_r;
    logic [N_LINES-1:0] pending_r;
    logic [CODE_W-1:0]  code_r;
    logic               valid_r;
    logic               overflow_r;
    state_t             state_r;

    logic [N_LINES-1:0] set_vec_s;
    logic [N_LINES-1:0] clr_vec_s;
    logic [N_LINES-1:0] next_pend_s;
    logic               hs_s;
    logic               ovf_s;
    logic [CODE_W-1:0]  start_s;
    logic [CODE_W-1:0]  sel_s;
    logic               any_s;

`ifdef ROUND_ROBIN_EN
    logic [CODE_W-1:0]  last_r;

    // Search resumes just after the code most recently accepted.
    always_comb begin
        if (hs_s) begin
            start_s = code_r + 2'd1;
        end else begin
            start_s = last_r + 2'd1;
        end
    end

    // Remember the last accepted code; 3 makes the first search start at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= 2'd3;
        end else if (hs_s) begin
            last_r <= code_r;
        end else begin
            last_r <= last_r;
        end
    end
`else
    assign start_s = 2'd0;
`endif

    // Capture, clear and collision terms for this cycle.
    always_comb begin
        if (EDGE_MODE) begin
            set_vec_s = rise_of(bus.i, prev_i_r);
        end else begin
            set_vec_s = bus.i;
        end
        hs_s = valid_r & bus.ready;
        if (hs_s) begin
            clr_vec_s = code_to_onehot(code_r);
        end else begin
            clr_vec_s = 4'b0000;
        end
        next_pend_s = pending_r & ~clr_vec_s;
        // Level mode re-sets pending every cycle by design, so no collision there.
        if (EDGE_MODE) begin
            ovf_s = |(set_vec_s & next_pend_s);
        end else begin
            ovf_s = 1'b0;
        end
    end

    prio_pick4 u_pick (
        .vec   (next_pend_s),
        .start (start_s),
        .code  (sel_s),
        .any   (any_s)
    );

    // Pending register, edge history and report FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_i_r   <= 4'b0000;
            pending_r  <= 4'b0000;
            code_r     <= 2'd0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            state_r    <= ST_IDLE;
        end else begin
            prev_i_r   <= bus.i;
            pending_r  <= next_pend_s | set_vec_s;
            overflow_r <= ovf_s;
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        code_r  <= sel_s;
                        valid_r <= 1'b1;
                        state_r <= ST_SHOW;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                ST_SHOW: begin
                    if (hs_s) begin
                        if (any_s) begin
                            code_r  <= sel_s;
                        end else begin
                            valid_r <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.A        = code_r[1];
    assign bus.B        = code_r[0];
    assign bus.valid    = valid_r;
    assign bus.pending  = pending_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_four_to_two_encoder.sv
// Directed bench for four_to_two_encoder: one edge-mode and one level-mode instance.
// Expected code order depends on ROUND_ROBIN_EN.
module tb_four_to_two_encoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   n_valid;
    logic [1:0] exp_seq [4];

    four_to_two_encoder_if bus ();
    four_to_two_encoder_if bus_lv ();

    four_to_two_encoder #(.EDGE_MODE(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    four_to_two_encoder #(.EDGE_MODE(1'b0)) dut_lv (
        .clk (clk),
        .rst (rst),
        .bus (bus_lv.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
`ifdef ROUND_ROBIN_EN
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3};
`else
        exp_seq = '{2'd3, 2'd2, 2'd1, 2'd0};
`endif
        rst = 1'b1;
        bus.i = 4'b0000;    bus.ready = 1'b0;
        bus_lv.i = 4'b0000; bus_lv.ready = 1'b0;

        // Reset state
        repeat (5) tick();
        check("rst_valid", {3'b000, bus.valid}, 4'b0000);
        check("rst_code", {2'b00, bus.A, bus.B}, 4'b0000);
        check("rst_pending", bus.pending, 4'b0000);
        check("rst_ovf", {3'b000, bus.overflow}, 4'b0000);
        rst = 1'b0;
        repeat (2) tick();
        check("idle_valid", {3'b000, bus.valid}, 4'b0000);

        // Single pulse on line 2
        bus.i = 4'b0100; bus.ready = 1'b1;
        tick();
        check("p_pend_n1", bus.pending, 4'b0100);
        check("p_valid_n1", {3'b000, bus.valid}, 4'b0000);
        bus.i = 4'b0000;
        tick();
        check("p_valid_n2", {3'b000, bus.valid}, 4'b0001);
        check("p_code_n2", {2'b00, bus.A, bus.B}, 4'b0010);
        tick();
        check("p_valid_done", {3'b000, bus.valid}, 4'b0000);
        check("p_pend_done", bus.pending, 4'b0000);

        // All four lines at once, stalled then drained
        bus.ready = 1'b0; bus.i = 4'b1111;
        tick();
        check("all_pend", bus.pending, 4'b1111);
        bus.i = 4'b0000;
        tick();
        check("all_valid", {3'b000, bus.valid}, 4'b0001);
        check("all_code0", {2'b00, bus.A, bus.B}, {2'b00, exp_seq[0]});
        for (int k = 0; k < 2; k++) begin
            tick();
            check("all_stall", {2'b00, bus.A, bus.B}, {2'b00, exp_seq[0]});
        end
        bus.ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            check("all_bvalid", {3'b000, bus.valid}, 4'b0001);
            check("all_code", {2'b00, bus.A, bus.B}, {2'b00, exp_seq[k]});
        end
        tick();
        check("all_end_valid", {3'b000, bus.valid}, 4'b0000);
        check("all_end_pend", bus.pending, 4'b0000);

        // Double pulse on line 1 while a code is stalled
        bus.ready = 1'b0; bus.i = 4'b1000;
        tick();
        bus.i = 4'b0000;
        tick();
        check("ov_show3", {2'b00, bus.A, bus.B}, 4'b0011);
        bus.i = 4'b0010;
        tick();
        check("ov_first", {3'b000, bus.overflow}, 4'b0000);
        check("ov_pend1", bus.pending, 4'b1010);
        bus.i = 4'b0000;
        tick();
        bus.i = 4'b0010;
        tick();
        check("ov_pulse", {3'b000, bus.overflow}, 4'b0001);
        check("ov_pend2", bus.pending, 4'b1010);
        bus.i = 4'b0000;
        tick();
        check("ov_drop", {3'b000, bus.overflow}, 4'b0000);
        bus.ready = 1'b1;
        tick();
        check("ov_code1", {2'b00, bus.A, bus.B}, 4'b0001);
        check("ov_valid1", {3'b000, bus.valid}, 4'b0001);
        tick();
        check("ov_once", {3'b000, bus.valid}, 4'b0000);
        check("ov_pend_end", bus.pending, 4'b0000);

        // Handshake on code 10 coinciding with a new edge on line 2
        bus.ready = 1'b0; bus.i = 4'b0100;
        tick();
        bus.i = 4'b0000;
        tick();
        check("sw_code", {2'b00, bus.A, bus.B}, 4'b0010);
        bus.i = 4'b0100; bus.ready = 1'b1;
        tick();
        check("sw_pend", bus.pending, 4'b0100);
        check("sw_ovf", {3'b000, bus.overflow}, 4'b0000);
        bus.i = 4'b0000;
        tick();
        check("sw_again_v", {3'b000, bus.valid}, 4'b0001);
        check("sw_again_c", {2'b00, bus.A, bus.B}, 4'b0010);
        tick();
        check("sw_end", bus.pending, 4'b0000);

        // Reset mid-handshake discards everything
        bus.ready = 1'b0; bus.i = 4'b1011;
        tick();
        bus.i = 4'b0000;
        tick();
        check("mr_valid", {3'b000, bus.valid}, 4'b0001);
        check("mr_pend", bus.pending, 4'b1011);
        rst = 1'b1;
        tick();
        check("mr_rvalid", {3'b000, bus.valid}, 4'b0000);
        check("mr_rpend", bus.pending, 4'b0000);
        check("mr_rcode", {2'b00, bus.A, bus.B}, 4'b0000);
        rst = 1'b0;

        // Level mode: line 0 held high keeps re-reporting code 00
        bus_lv.i = 4'b0001; bus_lv.ready = 1'b1;
        n_valid = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("lv_ovf", {3'b000, bus_lv.overflow}, 4'b0000);
            if (bus_lv.valid) begin
                n_valid++;
                check("lv_code", {2'b00, bus_lv.A, bus_lv.B}, 4'b0000);
            end else begin
                check("lv_pend", bus_lv.pending, 4'b0001);
            end
        end
        check("lv_repeats", {3'b000, (n_valid >= 3)}, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
